// File: rtl/combi_scoreboard_pkg.sv
// Shared types and constants for the combined ARM/RISC-V hazard scoreboard.
package combi_pkg;

    // Widest register index an entry can hold; narrower indices are zero-extended.
    localparam int SB_RD_W    = 8;
    // Forward select meaning "take the operand from the register file".
    localparam int FWD_RF     = 0;
    // ARM r15 reads are PC-derived and never forwarded.
    localparam int ARM_PC_REG = 15;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               regwrite;
        logic               load;
        logic               arm;
        logic               pcwrite;
    } sb_entry_t;

endpackage

// File: rtl/combi_scoreboard_match.sv
// sb_match: youngest-first search of the slot pipeline for one source register.
module sb_match
    import combi_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int FW    = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] slots,
    input  logic [REG_W-1:0]      src,
    input  logic                  srcArm,
    output logic                  hit,
    output logic [FW-1:0]         k,
    output logic                  isLoad
);

    logic excluded;
    logic unusedFields;

    // RISC-V x0 and ARM r15 never depend on an in-flight writer.
    assign excluded = (!srcArm && (src == '0)) ||
                      (srcArm && (src == REG_W'(ARM_PC_REG)));

    // Scan oldest to youngest so the lowest matching slot overwrites the rest.
    always_comb begin
        hit    = 1'b0;
        k      = '0;
        isLoad = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!excluded && slots[i].valid && slots[i].regwrite &&
                (slots[i].rd == SB_RD_W'(src))) begin
                hit    = 1'b1;
                k      = FW'(i);
                isLoad = slots[i].load;
            end
        end
    end

    // ISA and PC-write tags are carried for the top level, not needed here.
    always_comb begin
        unusedFields = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unusedFields = unusedFields ^ slots[i].arm ^ slots[i].pcwrite;
        end
    end

endmodule

// File: rtl/combi_scoreboard.sv
// combi_scoreboard: parametrised E..W hazard tracker producing decode stall/flush
// and registered execute forwarding selects. Optional ARM PC-write tracking is
// enabled with the SB_PCWRITE_EN macro.
module combi_scoreboard
    import combi_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_SLOT = 2,
    parameter int FW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_d,
    input  logic             arm_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_d,
    input  logic             regwrite_d,
    input  logic             load_d,
`ifdef SB_PCWRITE_EN
    input  logic             pcwrite_d,
`endif
    input  logic             flush_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [FW-1:0]    fwd_a_e,
    output logic [FW-1:0]    fwd_b_e,
    output logic             busy
);

    sb_entry_t [DEPTH-1:0] slots;
    sb_entry_t             newEntry;

    logic          hitA, hitB;
    logic [FW-1:0] kA, kB;
    logic          loadA, loadB;
    logic          loadUseA, loadUseB;
    logic          enterSlot;
    logic          pcPending;
    logic [FW-1:0] fwdANext, fwdBNext;

    sb_match #(.REG_W(REG_W), .DEPTH(DEPTH), .FW(FW)) matchA (
        .slots  (slots),
        .src    (rs1_d),
        .srcArm (arm_d),
        .hit    (hitA),
        .k      (kA),
        .isLoad (loadA)
    );

    sb_match #(.REG_W(REG_W), .DEPTH(DEPTH), .FW(FW)) matchB (
        .slots  (slots),
        .src    (rs2_d),
        .srcArm (arm_d),
        .hit    (hitB),
        .k      (kB),
        .isLoad (loadB)
    );

    // A load too young to have its data forwardable blocks the consumer in decode.
    always_comb begin
        loadUseA  = issue_d && hitA && loadA && ((int'(kA) + 1) < LOAD_SLOT);
        loadUseB  = issue_d && hitB && loadB && ((int'(kB) + 1) < LOAD_SLOT);
        stall_d   = loadUseA || loadUseB;
        enterSlot = issue_d && !stall_d && !flush_e;
    end

`ifdef SB_PCWRITE_EN
    // A PC write in flight until W means the fetched/decoded path is wrong.
    always_comb begin
        pcPending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pcPending = pcPending || (slots[i].valid && slots[i].pcwrite);
        end
    end
`else
    assign pcPending = 1'b0;
`endif

    assign stall_f = stall_d || pcPending;
    assign flush_d = pcPending;

    // Build the decode entry; a stalled or flushed decode becomes a bubble.
    always_comb begin
        newEntry          = '0;
        newEntry.valid    = enterSlot;
        newEntry.rd       = SB_RD_W'(rd_d);
        newEntry.regwrite = regwrite_d;
        newEntry.load     = load_d;
        newEntry.arm      = arm_d;
`ifdef SB_PCWRITE_EN
        newEntry.pcwrite  = pcwrite_d;
`else
        newEntry.pcwrite  = 1'b0;
`endif
    end

    // Forward from slot k+1 next cycle; the W slot writes the register file instead.
    always_comb begin
        fwdANext = FW'(FWD_RF);
        fwdBNext = FW'(FWD_RF);
        if (enterSlot && hitA && (int'(kA) < DEPTH - 1)) begin
            fwdANext = FW'(int'(kA) + 1);
        end
        if (enterSlot && hitB && (int'(kB) < DEPTH - 1)) begin
            fwdBNext = FW'(int'(kB) + 1);
        end
    end

    // Slot pipeline: decode -> slot 0, then every entry ages by one slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].valid <= 1'b0;
            end
        end else begin
            slots[0] <= newEntry;
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // Execute-stage forward selects, one register stage after decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_a_e <= FW'(FWD_RF);
            fwd_b_e <= FW'(FWD_RF);
        end else begin
            fwd_a_e <= fwdANext;
            fwd_b_e <= fwdBNext;
        end
    end

    // Occupancy indicator.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy || slots[i].valid;
        end
    end

endmodule

// File: tb/tb_combi_scoreboard.sv
// Directed bench for combi_scoreboard with default parameters
// (DEPTH=3, LOAD_SLOT=2). PC-write checks build only with SB_PCWRITE_EN.
module tb_combi_scoreboard;

    logic       clk;
    logic       rst;
    logic       issueD, armD, regwriteD, loadD, flushE;
    logic [4:0] rs1D, rs2D, rdD;
`ifdef SB_PCWRITE_EN
    logic       pcwriteD;
`endif
    logic       stallF, stallD, flushD, busy;
    logic [1:0] fwdAE, fwdBE;

    int nChecks = 0;
    int nPass   = 0;

    combi_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .issue_d    (issueD),
        .arm_d      (armD),
        .rs1_d      (rs1D),
        .rs2_d      (rs2D),
        .rd_d       (rdD),
        .regwrite_d (regwriteD),
        .load_d     (loadD),
`ifdef SB_PCWRITE_EN
        .pcwrite_d  (pcwriteD),
`endif
        .flush_e    (flushE),
        .stall_f    (stallF),
        .stall_d    (stallD),
        .flush_d    (flushD),
        .fwd_a_e    (fwdAE),
        .fwd_b_e    (fwdBE),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic iss, input logic arm, input int rs1, input int rs2,
                      input int rd, input logic rw, input logic ld);
        issueD    = iss;
        armD      = arm;
        rs1D      = 5'(rs1);
        rs2D      = 5'(rs2);
        rdD       = 5'(rd);
        regwriteD = rw;
        loadD     = ld;
        flushE    = 1'b0;
`ifdef SB_PCWRITE_EN
        pcwriteD  = 1'b0;
`endif
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (4) cyc();
    endtask

    task automatic randIn();
        issueD    = 1'($urandom);
        armD      = 1'($urandom);
        rs1D      = 5'($urandom);
        rs2D      = 5'($urandom);
        rdD       = 5'($urandom);
        regwriteD = 1'($urandom);
        loadD     = 1'($urandom);
        flushE    = 1'($urandom);
`ifdef SB_PCWRITE_EN
        pcwriteD  = 1'($urandom);
`endif
    endtask

    initial begin
        // Reset with random inputs.
        rst = 1'b0;
        randIn();
        cyc();
        randIn();
        cyc();
        randIn();
        #1;
        checkVal("rst_stall_d", stallD, 0);
        checkVal("rst_stall_f", stallF, 0);
        checkVal("rst_flush_d", flushD, 0);
        checkVal("rst_fwd_a", fwdAE, 0);
        checkVal("rst_fwd_b", fwdBE, 0);
        checkVal("rst_busy", busy, 0);
        rst = 1'b1;
        drain();

        // Adjacent RISC-V dependency: forward from slot 0.
        op(1, 0, 1, 2, 5, 1, 0);
        cyc();
        op(1, 0, 5, 5, 6, 1, 0);
        #1;
        checkVal("adj_nostall", stallD, 0);
        checkVal("adj_busy", busy, 1);
        cyc();
        checkVal("adj_fwd_a", fwdAE, 1);
        checkVal("adj_fwd_b", fwdBE, 1);
        drain();

        // One-instruction gap: forward from slot 1.
        op(1, 0, 1, 2, 5, 1, 0);
        cyc();
        idle();
        cyc();
        op(1, 0, 5, 5, 6, 1, 0);
        cyc();
        checkVal("gap1_fwd_a", fwdAE, 2);
        checkVal("gap1_fwd_b", fwdBE, 2);
        drain();

        // Two-instruction gap: producer in W, register file supplies it.
        op(1, 0, 1, 2, 5, 1, 0);
        cyc();
        idle();
        cyc();
        cyc();
        op(1, 0, 5, 5, 6, 1, 0);
        cyc();
        checkVal("gap2_fwd_a", fwdAE, 0);
        checkVal("gap2_fwd_b", fwdBE, 0);
        drain();

        // Load-use: one stall cycle, bubble in E, then forward from slot 2.
        op(1, 0, 1, 0, 6, 1, 1);
        cyc();
        op(1, 0, 6, 0, 7, 1, 0);
        #1;
        checkVal("lu_stall_d", stallD, 1);
        checkVal("lu_stall_f", stallF, 1);
        checkVal("lu_flush_d", flushD, 0);
        cyc();
        checkVal("lu_bubble_fwd_a", fwdAE, 0);
        checkVal("lu_stall_released", stallD, 0);
        cyc();
        checkVal("lu_fwd_a", fwdAE, 2);
        checkVal("lu_fwd_b", fwdBE, 0);
        drain();

        // RISC-V x0: a load to x0 neither forwards nor stalls.
        op(1, 0, 1, 2, 0, 1, 1);
        cyc();
        op(1, 0, 0, 0, 8, 1, 0);
        #1;
        checkVal("x0_nostall", stallD, 0);
        cyc();
        checkVal("x0_fwd_a", fwdAE, 0);
        checkVal("x0_fwd_b", fwdBE, 0);
        drain();

        // ARM r0 is a real register.
        op(1, 1, 1, 2, 0, 1, 0);
        cyc();
        op(1, 1, 0, 0, 3, 1, 0);
        cyc();
        checkVal("arm_r0_fwd_a", fwdAE, 1);
        checkVal("arm_r0_fwd_b", fwdBE, 1);
        drain();

        // ARM r15 reads are never forwarded, even after a load to r15.
        op(1, 1, 1, 2, 15, 1, 1);
        cyc();
        op(1, 1, 15, 15, 3, 1, 0);
        #1;
        checkVal("arm_r15_nostall", stallD, 0);
        cyc();
        checkVal("arm_r15_fwd_a", fwdAE, 0);
        checkVal("arm_r15_fwd_b", fwdBE, 0);
        drain();

        // Youngest writer wins.
        op(1, 0, 1, 2, 7, 1, 0);
        cyc();
        op(1, 0, 1, 2, 7, 1, 0);
        cyc();
        op(1, 0, 7, 7, 9, 1, 0);
        cyc();
        checkVal("young_fwd_a", fwdAE, 1);
        drain();

        // Older writer is a load, younger ALU write shadows it: no stall.
        op(1, 0, 1, 2, 7, 1, 1);
        cyc();
        op(1, 0, 1, 2, 7, 1, 0);
        cyc();
        op(1, 0, 7, 2, 9, 1, 0);
        #1;
        checkVal("young_ld_nostall", stallD, 0);
        cyc();
        checkVal("young_ld_fwd_a", fwdAE, 1);
        drain();

        // Load killed by flush_e as it enters E never stalls the consumer.
        op(1, 0, 1, 2, 6, 1, 1);
        flushE = 1'b1;
        cyc();
        op(1, 0, 6, 6, 7, 1, 0);
        #1;
        checkVal("flush_nostall", stallD, 0);
        checkVal("flush_busy", busy, 0);
        cyc();
        checkVal("flush_fwd_a", fwdAE, 0);
        drain();

        // Reset mid-operation discards the in-flight producer.
        op(1, 0, 1, 2, 5, 1, 0);
        cyc();
        op(1, 0, 5, 5, 6, 1, 0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        checkVal("midrst_fwd_a", fwdAE, 0);
        checkVal("midrst_busy", busy, 0);
        cyc();
        checkVal("midrst_after_fwd_a", fwdAE, 0);
        drain();

`ifdef SB_PCWRITE_EN
        // ARM PC write holds fetch and flushes decode for DEPTH-1 cycles.
        op(1, 1, 1, 2, 15, 1, 0);
        pcwriteD = 1'b1;
        cyc();
        idle();
        #1;
        checkVal("pc_stall_f_1", stallF, 1);
        checkVal("pc_flush_d_1", flushD, 1);
        checkVal("pc_stall_d_1", stallD, 0);
        cyc();
        checkVal("pc_stall_f_2", stallF, 1);
        checkVal("pc_flush_d_2", flushD, 1);
        cyc();
        checkVal("pc_stall_f_3", stallF, 0);
        checkVal("pc_flush_d_3", flushD, 0);
        drain();
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/combi_scoreboard.md
# combi_scoreboard

Parametrised hazard scoreboard for the combined ARM/RISC-V pipeline, replacing the fixed E/M/W hazard logic. It tracks each in-flight instruction's destination register in a shift pipeline of configurable depth. It produces decode-stage stall/flush and registered execute-stage forwarding selects. Load-use distance, depth and register-index width are parameters, and register-zero handling is per-ISA.

## Interface
- `REG_W`, 5: register index width.
- `DEPTH`, 3: tracked slots after decode; slot 0 = E, slot DEPTH-1 = W; legal 2..8.
- `LOAD_SLOT`, 2: first slot whose load data is forwardable; legal 1..DEPTH-1.
- `FW`, $clog2(DEPTH): forward-select width (derived, do not override).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `issue_d` in 1: valid instruction in decode.
- `arm_d` in 1: decode instruction is ARM (0 = RISC-V).
- `rs1_d`, `rs2_d` in REG_W: decode source registers.
- `rd_d` in REG_W: decode destination.
- `regwrite_d` in 1: decode instruction writes `rd_d`.
- `load_d` in 1: decode instruction is a load.
- `pcwrite_d` in 1: ARM write to PC; exists only with `SB_PCWRITE_EN`.
- `flush_e` in 1: kill the instruction entering E (branch taken).
- `stall_f`, `stall_d` out 1: hold F and D (combinational).
- `flush_d` out 1: bubble D (combinational).
- `fwd_a_e`, `fwd_b_e` out FW: execute operand source (registered); 0 = register file, j = result of slot j.
- `busy` out 1: any slot valid.

## Operation
- Each slot holds valid, rd, regwrite, load, arm and pcwrite.
- Every cycle slot i+1 takes slot i.
- Slot 0 loads the decode entry only when `issue_d & ~stall_d & ~flush_e`; otherwise it becomes a bubble (valid=0).
- Match for source s at slot k requires all of:
  - valid & regwrite & rd == s;
  - not (RISC-V source and s == 0);
  - not (ARM source and s == 15; r15 reads are PC-derived).
- ARM r0 is a real register and matches normally.
- The youngest match (lowest k) wins, with no further search.
- The youngest match at k = DEPTH-1 gives no forward. The register file is written this cycle, and write-before-read is guaranteed.
- Load-use: stall when the youngest match is a load and k+1 < LOAD_SLOT.
- `stall_d` is asserted for a load-use hazard on either source, gated by `issue_d`.
- `stall_f = stall_d`.
- Forward-register update, when the entry enters slot 0: `fwd_x_e <= k+1` if the youngest match has k+1 ≤ DEPTH-1, else 0.
- Forward-register update, on bubble: `fwd_x_e <= 0`.
- `flush_e` takes priority over issue. A flushed load never causes a later stall.
- `flush_d` is 0 unless `SB_PCWRITE_EN` is defined.

## Timing
- Reset (`rst`=0 at clk edge): all slots invalid, `fwd_a_e`/`fwd_b_e`=0, `busy`=0. `stall_*`/`flush_d` are therefore 0 for the following cycle.
- Reset mid-operation discards all in-flight state with no drain.
- Forward selects are valid for the whole E cycle of the consumer: one register stage after decode.
- Load-use stall lasts LOAD_SLOT-1-k cycles. With defaults, an adjacent load-use stalls exactly 1 cycle, then `fwd`=2.
- Stall and flush are combinational from the slot state and the decode inputs within the same cycle.

## Configuration
- `SB_PCWRITE_EN` defined:
  - `pcwrite_d` port present and tracked.
  - While any valid slot 0..DEPTH-2 holds pcwrite: `stall_f`=1 and `flush_d`=1.
  - `stall_f` = load-use OR pcwrite-pending.
  - `stall_d` remains load-use only.
- Undefined: port absent, pcwrite bits constant 0, `flush_d` tied 0.

## Structure
- `combi_pkg` holds:
  - `sb_entry_t` struct {valid, rd, regwrite, load, arm, pcwrite};
  - `FWD_RF` = 0;
  - `ARM_PC_REG` = 15.
- One sub-module, `sb_match`: a priority search over slots returning hit, youngest k and is-load for one source. It is instantiated twice (rs1, rs2).

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random inputs → all outputs 0, `busy`=0.
- RISC-V `add x5` then `add x6,x5,x5` next cycle → consumer E cycle `fwd_a_e`=`fwd_b_e`=1. Repeat with one-instruction gap → 2. Two-instruction gap → 0.
- Load-use: `lw x6` then `add x7,x6,x0` → `stall_d`=`stall_f`=1 for exactly 1 cycle, bubble in E (`fwd`=0), then consumer `fwd_a_e`=2, `fwd_b_e`=0.
- Register zero:
  - RISC-V write of x0 then read of x0 → `fwd`=0, no stall.
  - ARM write of r0 then read → `fwd`=1.
  - ARM read of r15 after r15 write → `fwd`=0.
- Youngest wins: writes to x7 in consecutive cycles, then read x7 → `fwd`=1, not 2. Same sequence with the older write a load → no stall.
- `flush_e` asserted as a load enters E, consumer follows → no stall, `fwd`=0. With `SB_PCWRITE_EN`: ARM PC write → `stall_f`=`flush_d`=1 for DEPTH-1 cycles, then 0.
